// File: rtl/adder_eval_pkg.sv
// Shared definitions for the approximate-adder error evaluation blocks:
// operand width, accumulator FSM states and the error-distance helper.
package adder_eval_pkg;

  localparam int OP_W = 8;
  localparam int ED_W = OP_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

  // Unsigned magnitude of the difference between two OP_W+1-bit sums.
  function automatic logic [ED_W-1:0] err_dist(input logic [ED_W-1:0] x,
                                               input logic [ED_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/adder_error_accumulator_if.sv
// Sample bus between the approximate adder under test and the accumulator:
// one operand pair plus the approximate sum, with a valid/ready handshake.
interface adder_error_accumulator_if;
  import adder_eval_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic [ED_W-1:0] approx_sum;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output approx_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  approx_sum,
    output in_ready
  );

endinterface

// File: rtl/adder_error_dist.sv
// Stage 1 of the error pipeline: recomputes the exact sum of an accepted
// operand pair and registers its distance from the approximate sum.
module adder_error_dist
  import adder_eval_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  input  logic [ED_W-1:0] approx_sum,
  output logic            ed_valid,
  output logic [ED_W-1:0] ed
);

  logic [ED_W-1:0] exact;

  assign exact = {1'b0, op_a} + {1'b0, op_b};

  // Capture the error distance of each accepted sample; a flush drops any entry in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ed_valid <= 1'b0;
      ed       <= '0;
    end else if (flush) begin
      ed_valid <= 1'b0;
      ed       <= '0;
    end else begin
      ed_valid <= load;
      if (load) begin
        ed <= err_dist(exact, approx_sum);
      end
    end
  end

endmodule

// File: rtl/adder_error_accumulator.sv
// Error-statistics stage for an approximate adder: accepts N_SAMPLES operand
// pairs per run and accumulates sample count, erroneous-sample count,
// error-distance sum and maximum error distance, raising done at run end.
module adder_error_accumulator
  import adder_eval_pkg::*;
#(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = ED_W + CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  adder_error_accumulator_if.slave    bus,
  output logic                        done,
  output logic [CNT_W-1:0]            sample_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [SUM_W-1:0]            ed_sum,
  output logic [ED_W-1:0]             ed_max
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  acc_state_e      state;
  acc_state_e      state_next;
  logic [CNT_W-1:0] accept_cnt;
  logic            accept;
  logic            last_accept;
  logic            begin_run;
  logic            s1_valid;
  logic [ED_W-1:0] s1_ed;
  logic            s2_valid;

  assign bus.in_ready = (state == RUN);
  assign done         = (state == DONE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign last_accept  = accept && (accept_cnt == LAST_IDX);
  assign begin_run    = start && !clear && ((state == IDLE) || (state == DONE));

  adder_error_dist u_dist (
    .clk        (clk),
    .rst        (rst),
    .flush      (clear),
    .load       (accept),
    .op_a       (bus.op_a),
    .op_b       (bus.op_b),
    .approx_sum (bus.approx_sum),
    .ed_valid   (s1_valid),
    .ed         (s1_ed)
  );

  // Run-control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: clear always wins, DRAIN waits for both stages to empty.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (last_accept) state_next = DRAIN;
        DRAIN:   if (!s1_valid && !s2_valid) state_next = DONE;
        DONE:    if (start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Count accepted samples so the run ends after exactly N_SAMPLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt <= '0;
    end else if (clear || begin_run) begin
      accept_cnt <= '0;
    end else if (accept) begin
      accept_cnt <= accept_cnt + CNT_W'(1);
    end
  end

  // Stage 2: fold each valid stage-1 error distance into the run statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (clear || begin_run) begin
      s2_valid   <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        err_cnt    <= err_cnt + CNT_W'(s1_ed != '0);
        ed_sum     <= ed_sum + SUM_W'(s1_ed);
        if (s1_ed > ed_max) begin
          ed_max <= s1_ed;
        end
      end
    end
  end

endmodule

// File: doc/adder_error_accumulator.md
# adder_error_accumulator

Sequential error-statistics stage that sits directly downstream of an approximate 8-bit adder under evaluation. Each cycle it accepts one operand pair plus the approximate 9-bit sum produced for it, recomputes the exact sum, and forms the error distance. Over a run of `N_SAMPLES` pairs it accumulates sample count, erroneous-sample count, error-distance sum and maximum error distance. Results are reported to the error-evaluation harness at the end of the run.

## Interface
- `OP_W`, 8: operand width; sums and error distances are `OP_W+1` bits.
- `N_SAMPLES`, 65536: samples per run (default covers the exhaustive 16-bit input space).
- `CNT_W`, 17: counter width, ≥ clog2(`N_SAMPLES`+1).
- `SUM_W`, `OP_W+1+CNT_W` (26): error-distance accumulator width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a run.
- `clear` in 1: single-cycle pulse; aborts and zeroes.
- `in_valid` in 1: sample present.
- `in_ready` out 1: block accepts a sample this cycle.
- `op_a` in `OP_W`: operand A.
- `op_b` in `OP_W`: operand B.
- `approx_sum` in `OP_W+1`: DUT sum; bit `OP_W` is carry-out.
- `done` out 1: run complete, results stable.
- `sample_cnt` out `CNT_W`: samples accumulated.
- `err_cnt` out `CNT_W`: samples with nonzero error distance.
- `ed_sum` out `SUM_W`: Σ |exact − approx|.
- `ed_max` out `OP_W+1`: max |exact − approx|.

## Operation
- FSM states are IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE: `start` zeroes all accumulators and the accept counter, then goes to RUN.
- RUN: `in_ready`=1. A sample is accepted when `in_valid && in_ready`. When the accept counter reaches `N_SAMPLES`, `in_ready` drops the same cycle the last sample is accepted, and the FSM goes to DRAIN.
- DRAIN: waits until both pipeline stages are empty (2 cycles), then goes to DONE.
- DONE: `done`=1 and outputs hold. `start` restarts exactly as from IDLE.
- `clear` in any state: returns to IDLE, zeroes accumulators, flushes the pipeline. `clear` has priority over `start` in the same cycle.
- `start` in RUN or DRAIN is ignored.
- Stage 1 (registered):
  - exact = zero-extended `op_a` + `op_b` (`OP_W+1` bits, no overflow).
  - ed = |exact − `approx_sum`|, computed as an unsigned `OP_W+1`-bit magnitude (range 0..511).
- Stage 2 (accumulate, only on a valid stage-1 entry):
  - `sample_cnt`+=1.
  - `err_cnt`+=(ed≠0).
  - `ed_sum`+=ed.
  - `ed_max`=max(`ed_max`,ed).
- No saturation is needed: the default widths cannot overflow for `N_SAMPLES` ≤ 2^(`CNT_W`)−1.
- `in_valid` gaps are allowed; bubbles propagate and accumulate nothing.

## Timing
- Reset values: `in_ready`=0, `done`=0, and `sample_cnt`, `err_cnt`, `ed_sum`, `ed_max` all 0. Pipeline valid bits are 0.
- `in_ready` rises 1 cycle after `start`.
- Latency from sample accept to its effect on the accumulator outputs: 2 cycles.
- `done` rises 3 cycles after the last accept (2 pipeline cycles + DONE entry). All outputs are final and stable whenever `done`=1.
- Outputs update live during RUN; they are valid only when `done`=1.
- Asynchronous `rst` mid-run immediately forces reset values. The partial run is discarded.
- `clear` takes effect on the next edge: outputs read 0 and `in_ready`=0 from the following cycle.
- `N_SAMPLES`=1 is legal: a single accept goes RUN→DRAIN directly.

## Structure
- Shared package `adder_eval_pkg`:
  - `OP_W` default.
  - FSM state enum `acc_state_e`.
  - The `err_dist` function, computing |x−y| on `OP_W+1` bits.
- One natural sub-module, `adder_error_dist`: stage-1 register holding the exact-sum and error-distance computation. The FSM and accumulators live in the top.

## Test plan
- Exact DUT model (approx = `op_a`+`op_b`), all 65536 pairs, `in_valid` held high → `sample_cnt`=65536, `err_cnt`=0, `ed_sum`=0, `ed_max`=0, `done` 3 cycles after last accept.
- Truncating model (approx = exact & 9'h1E0), exhaustive → `err_cnt`=63488, `ed_sum`=1015808, `ed_max`=31.
- `N_SAMPLES`=4, samples (255,255,0), (0,0,511), (1,2,3), (1,2,0), with `in_valid` low every other cycle → `sample_cnt`=4, `err_cnt`=3, `ed_sum`=1024, `ed_max`=511.
- `clear` asserted after 100 accepts, then `start` → run completes with counts from the new run only. `clear`+`start` in the same cycle → stays IDLE.
- `rst` asserted mid-DRAIN → all outputs 0 in the same cycle, `done`=0. After release, a fresh `start` runs normally.
- `start` pulsed during RUN and DRAIN → ignored, counts unaffected. `start` in DONE → accumulators zeroed, new run begins.
